// File: rtl/div_issue_ctrl_pkg.sv
// Shared constants for the divider issue controller: FSM state encoding and default width.
package div_issue_ctrl_pkg;

  localparam int unsigned DivDataW = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StDone  = 3'd3,
    StDrain = 3'd4
  } div_state_e;

endpackage

// File: rtl/axis_sticky_issue.sv
// One AXI-Stream operand channel: offers tvalid while active until the beat is taken, then
// remembers the acceptance so the beat is never sent twice.
module axis_sticky_issue (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic clr,
  input  logic tready,
  output logic tvalid,
  output logic acc_nxt
);

  logic acc_q;

  assign tvalid  = active & ~acc_q;
  // Includes a handshake happening this cycle, so the owner can move on without a bubble.
  assign acc_nxt = acc_q | (tvalid & tready);

  // Sticky accepted flag: set on handshake, cleared whenever the owner is not issuing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= 1'b0;
    end else if (clr) begin
      acc_q <= 1'b0;
    end else if (tvalid & tready) begin
      acc_q <= 1'b1;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequences one divide request from EXE through the signed or unsigned divider core and holds
// the selected quotient/remainder until EXE consumes it. Flushed requests whose operands have
// reached a core are drained so the owed result is swallowed.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DivDataW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_signed,
  input  logic                req_rem,
  input  logic [DATA_W-1:0]   req_src1,
  input  logic [DATA_W-1:0]   req_src2,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_result,
  input  logic                resp_ready,
  input  logic                flush,
  output logic                busy,
  output logic [DATA_W-1:0]   div_dividend_tdata,
  output logic [DATA_W-1:0]   div_divisor_tdata,
  output logic                sdiv_dividend_tvalid,
  input  logic                sdiv_dividend_tready,
  output logic                sdiv_divisor_tvalid,
  input  logic                sdiv_divisor_tready,
  input  logic                sdiv_dout_tvalid,
  input  logic [2*DATA_W-1:0] sdiv_dout_tdata,
  output logic                udiv_dividend_tvalid,
  input  logic                udiv_dividend_tready,
  output logic                udiv_divisor_tvalid,
  input  logic                udiv_divisor_tready,
  input  logic                udiv_dout_tvalid,
  input  logic [2*DATA_W-1:0] udiv_dout_tdata
);

  div_state_e          state_q;
  logic                req_ready_q, resp_valid_q, busy_q;
  logic                sel_signed_q, sel_rem_q, drain_pend_q;
  logic [DATA_W-1:0]   dividend_q, divisor_q, resp_result_q;

  logic                accept, issuing, s_active, u_active;
  logic                s_dvd_acc, s_dvs_acc, u_dvd_acc, u_dvs_acc;
  logic                dvd_acc, dvs_acc, any_acc, both_acc;
  logic                dout_sel;
  logic [2*DATA_W-1:0] dout_data;
  logic [DATA_W-1:0]   dout_pick;

  assign accept   = req_valid & req_ready_q & ~flush;
  assign issuing  = (state_q == StIssue);
  assign s_active = issuing & sel_signed_q;
  assign u_active = issuing & ~sel_signed_q;

  axis_sticky_issue u_sdiv_dividend (
    .clk     (clk),
    .reset   (reset),
    .active  (s_active),
    .clr     (~issuing),
    .tready  (sdiv_dividend_tready),
    .tvalid  (sdiv_dividend_tvalid),
    .acc_nxt (s_dvd_acc)
  );

  axis_sticky_issue u_sdiv_divisor (
    .clk     (clk),
    .reset   (reset),
    .active  (s_active),
    .clr     (~issuing),
    .tready  (sdiv_divisor_tready),
    .tvalid  (sdiv_divisor_tvalid),
    .acc_nxt (s_dvs_acc)
  );

  axis_sticky_issue u_udiv_dividend (
    .clk     (clk),
    .reset   (reset),
    .active  (u_active),
    .clr     (~issuing),
    .tready  (udiv_dividend_tready),
    .tvalid  (udiv_dividend_tvalid),
    .acc_nxt (u_dvd_acc)
  );

  axis_sticky_issue u_udiv_divisor (
    .clk     (clk),
    .reset   (reset),
    .active  (u_active),
    .clr     (~issuing),
    .tready  (udiv_divisor_tready),
    .tvalid  (udiv_divisor_tvalid),
    .acc_nxt (u_dvs_acc)
  );

  assign dvd_acc  = sel_signed_q ? s_dvd_acc : u_dvd_acc;
  assign dvs_acc  = sel_signed_q ? s_dvs_acc : u_dvs_acc;
  assign any_acc  = dvd_acc | dvs_acc;
  assign both_acc = dvd_acc & dvs_acc;

  // Results from the unselected core are never looked at.
  assign dout_sel  = sel_signed_q ? sdiv_dout_tvalid : udiv_dout_tvalid;
  assign dout_data = sel_signed_q ? sdiv_dout_tdata : udiv_dout_tdata;
  assign dout_pick = sel_rem_q ? dout_data[DATA_W-1:0] : dout_data[2*DATA_W-1:DATA_W];

  // Request sequencing FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      resp_result_q <= '0;
      dividend_q    <= '0;
      divisor_q     <= '0;
      sel_signed_q  <= 1'b0;
      sel_rem_q     <= 1'b0;
      drain_pend_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q      <= StIssue;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            dividend_q   <= req_src1;
            divisor_q    <= req_src2;
            sel_signed_q <= req_signed;
            sel_rem_q    <= req_rem;
            drain_pend_q <= 1'b0;
          end
        end
        StIssue: begin
          if (flush && !any_acc) begin
            // Nothing reached the core yet, so no result will ever be owed.
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (both_acc) begin
            state_q <= (flush || drain_pend_q) ? StDrain : StWait;
          end else if (flush) begin
            // Part of the operand pair is in the core; finish the pair, then drain.
            drain_pend_q <= 1'b1;
          end
        end
        StWait: begin
          if (dout_sel) begin
            if (flush) begin
              // The owed result arrives with the flush: drop it and skip draining.
              state_q     <= StIdle;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q       <= StDone;
              resp_valid_q  <= 1'b1;
              resp_result_q <= dout_pick;
            end
          end else if (flush) begin
            state_q <= StDrain;
          end
        end
        StDone: begin
          if (flush || resp_ready) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
          end
        end
        StDrain: begin
          if (dout_sel) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q      <= StIdle;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready          = req_ready_q;
  assign resp_valid         = resp_valid_q;
  assign resp_result        = resp_result_q;
  assign busy               = busy_q;
  assign div_dividend_tdata = dividend_q;
  assign div_divisor_tdata  = divisor_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: the bench plays both divider cores, schedules operand
// acceptance and result pulses per transaction, and checks outputs cycle by cycle.
module tb_div_issue_ctrl;

  localparam int unsigned W = 32;

  // Transaction endings
  localparam int ModeNormal    = 0;
  localparam int ModeFlushWait = 1;
  localparam int ModeFlushIss0 = 2;
  localparam int ModeFlushDone = 3;
  localparam int ModeFlushIss1 = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid, req_ready, req_signed, req_rem;
  logic [W-1:0]   req_src1, req_src2;
  logic           resp_valid, resp_ready, flush, busy;
  logic [W-1:0]   resp_result, div_dividend_tdata, div_divisor_tdata;
  logic           sdiv_dividend_tvalid, sdiv_dividend_tready;
  logic           sdiv_divisor_tvalid, sdiv_divisor_tready;
  logic           sdiv_dout_tvalid;
  logic [2*W-1:0] sdiv_dout_tdata;
  logic           udiv_dividend_tvalid, udiv_dividend_tready;
  logic           udiv_divisor_tvalid, udiv_divisor_tready;
  logic           udiv_dout_tvalid;
  logic [2*W-1:0] udiv_dout_tdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DATA_W(W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_signed           (req_signed),
    .req_rem              (req_rem),
    .req_src1             (req_src1),
    .req_src2             (req_src2),
    .resp_valid           (resp_valid),
    .resp_result          (resp_result),
    .resp_ready           (resp_ready),
    .flush                (flush),
    .busy                 (busy),
    .div_dividend_tdata   (div_dividend_tdata),
    .div_divisor_tdata    (div_divisor_tdata),
    .sdiv_dividend_tvalid (sdiv_dividend_tvalid),
    .sdiv_dividend_tready (sdiv_dividend_tready),
    .sdiv_divisor_tvalid  (sdiv_divisor_tvalid),
    .sdiv_divisor_tready  (sdiv_divisor_tready),
    .sdiv_dout_tvalid     (sdiv_dout_tvalid),
    .sdiv_dout_tdata      (sdiv_dout_tdata),
    .udiv_dividend_tvalid (udiv_dividend_tvalid),
    .udiv_dividend_tready (udiv_dividend_tready),
    .udiv_divisor_tvalid  (udiv_divisor_tvalid),
    .udiv_divisor_tready  (udiv_divisor_tready),
    .udiv_dout_tvalid     (udiv_dout_tvalid),
    .udiv_dout_tdata      (udiv_dout_tdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference divider: {quotient, remainder}, truncating toward zero for the signed core.
  function automatic logic [2*W-1:0] ref_div(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [3:0] got_tv();
    return {sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid};
  endfunction

  function automatic logic [3:0] exp_tv(input logic sgn, input logic vd, input logic vs);
    return sgn ? {vd, vs, 2'b00} : {2'b00, vd, vs};
  endfunction

  task automatic set_rdy(input logic sgn, input logic rd, input logic rs);
    if (sgn) begin
      sdiv_dividend_tready = rd;
      sdiv_divisor_tready  = rs;
      udiv_dividend_tready = 1'($urandom);
      udiv_divisor_tready  = 1'($urandom);
    end else begin
      udiv_dividend_tready = rd;
      udiv_divisor_tready  = rs;
      sdiv_dividend_tready = 1'($urandom);
      sdiv_divisor_tready  = 1'($urandom);
    end
  endtask

  task automatic drive_dout(input logic sgn, input logic v, input logic [2*W-1:0] data);
    sdiv_dout_tvalid = sgn & v;
    udiv_dout_tvalid = ~sgn & v;
    sdiv_dout_tdata  = sgn ? data : {$urandom, $urandom};
    udiv_dout_tdata  = sgn ? {$urandom, $urandom} : data;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(1));
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({tag, "_resp_result"}, 64'(resp_result), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_tvalid"}, 64'(got_tv()), 64'(0));
  endtask

  // One transaction starting in IDLE at the current cycle (cycle 0 = accept). Each operand
  // channel is accepted dly cycles after tvalid first rises; the core answers lat cycles after
  // the second operand is accepted.
  task automatic run_op(input logic sgn, input logic rem, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int dvd, input int dvs, input int lat,
                        input int fl, input int mode, input int hold);
    logic [2*W-1:0] res;
    logic [W-1:0]   exp_res;
    int             h, d;
    res     = ref_div(sgn, a, b);
    exp_res = rem ? res[W-1:0] : res[2*W-1:W];
    h       = 1 + ((dvd > dvs) ? dvd : dvs);
    d       = h + 1 + lat;

    check("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid  = 1'b1;
    req_signed = sgn;
    req_rem    = rem;
    req_src1   = a;
    req_src2   = b;
    flush      = 1'b0;
    resp_ready = 1'b0;
    set_rdy(sgn, 1'b0, 1'b0);
    drive_dout(sgn, 1'b0, '0);
    tick();
    req_valid = 1'b0;
    req_src1  = $urandom;
    req_src2  = $urandom;

    // Operand issue
    for (int c = 1; c <= h; c++) begin
      check("tvalid_issue", 64'(got_tv()), 64'(exp_tv(sgn, c <= 1 + dvd, c <= 1 + dvs)));
      check("busy_issue", 64'(busy), 64'(1));
      check("dividend_tdata", 64'(div_dividend_tdata), 64'(a));
      check("divisor_tdata", 64'(div_divisor_tdata), 64'(b));
      set_rdy(sgn, (c == 1 + dvd) || (c > 1 + dvd && 1'($urandom)),
              (c == 1 + dvs) || (c > 1 + dvs && 1'($urandom)));
      flush = (mode == ModeFlushIss0 && c == 1) || (mode == ModeFlushIss1 && c == 2);
      tick();
      flush = 1'b0;
      if (mode == ModeFlushIss0) begin
        check("flush_iss0_tvalid", 64'(got_tv()), 64'(0));
        check("flush_iss0_busy", 64'(busy), 64'(0));
        check("flush_iss0_req_ready", 64'(req_ready), 64'(1));
        return;
      end
    end

    // Waiting for (or draining) the core result
    for (int c = h + 1; c <= d; c++) begin
      check("tvalid_wait", 64'(got_tv()), 64'(0));
      check("resp_valid_wait", 64'(resp_valid), 64'(0));
      check("busy_wait", 64'(busy), 64'(1));
      flush = (mode == ModeFlushWait && c == h + 1 + fl);
      drive_dout(sgn, c == d, res);
      tick();
    end
    flush = 1'b0;
    drive_dout(sgn, 1'b0, '0);

    if (mode == ModeFlushWait || mode == ModeFlushIss1) begin
      check("drain_resp_valid", 64'(resp_valid), 64'(0));
      check("drain_busy", 64'(busy), 64'(0));
      check("drain_req_ready", 64'(req_ready), 64'(1));
      return;
    end

    // Result held until consumed
    check("resp_valid", 64'(resp_valid), 64'(1));
    check("resp_result", 64'(resp_result), 64'(exp_res));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("resp_valid_hold", 64'(resp_valid), 64'(1));
      check("resp_result_hold", 64'(resp_result), 64'(exp_res));
      check("req_ready_done", 64'(req_ready), 64'(0));
    end
    if (mode == ModeFlushDone) flush = 1'b1;
    else resp_ready = 1'b1;
    tick();
    flush      = 1'b0;
    resp_ready = 1'b0;
    check("release_resp_valid", 64'(resp_valid), 64'(0));
    check("release_busy", 64'(busy), 64'(0));
    check("release_req_ready", 64'(req_ready), 64'(1));
  endtask

  initial begin
    logic       sgn, rem;
    logic [W-1:0] a, b;
    int         mode, dvd, dvs, lat, fl;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    req_rem    = 1'b0;
    req_src1   = '0;
    req_src2   = '0;
    resp_ready = 1'b0;
    flush      = 1'b0;
    set_rdy(1'b0, 1'b0, 1'b0);
    drive_dout(1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    tick();
    check_reset_vals("post_rst");

    // Signed -7 / 2, quotient then remainder
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h2, 0, 0, 3, 0, ModeNormal, 1);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2, 0, 0, 0, 0, ModeNormal, 0);
    // Unsigned 0xFFFFFFFF / 0x10
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h10, 0, 0, 2, 0, ModeNormal, 0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10, 0, 0, 1, 0, ModeNormal, 0);
    // Dividend accepted at t+1, divisor at t+4
    run_op(1'b1, 1'b0, 32'd1000, 32'd7, 0, 3, 2, 0, ModeNormal, 0);
    // Flush in WAIT, result 20 cycles later is drained; next op 6/3
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 0, 0, 20, 0, ModeFlushWait, 0);
    run_op(1'b0, 1'b0, 32'd6, 32'd3, 1, 0, 2, 0, ModeNormal, 0);
    // Result held 5 cycles before consumption
    run_op(1'b0, 1'b1, 32'd12345, 32'd100, 0, 0, 4, 0, ModeNormal, 5);
    // Flush before any operand accepted, with one accepted, and in DONE
    run_op(1'b1, 1'b1, 32'd50, 32'd9, 2, 1, 3, 0, ModeFlushIss0, 0);
    run_op(1'b0, 1'b0, 32'd77, 32'd5, 0, 3, 4, 0, ModeFlushIss1, 0);
    run_op(1'b1, 1'b0, 32'hFFFF_FF00, 32'd3, 1, 1, 2, 0, ModeFlushDone, 2);

    // A request presented together with flush is not accepted
    req_valid = 1'b1;
    flush     = 1'b1;
    req_src1  = 32'd9;
    req_src2  = 32'd3;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'(0));
    check("flush_idle_tvalid", 64'(got_tv()), 64'(0));

    // Reset in ISSUE, stale result ignored, next op completes
    req_valid  = 1'b1;
    req_signed = 1'b1;
    req_rem    = 1'b0;
    req_src1   = 32'd40;
    req_src2   = 32'd6;
    set_rdy(1'b1, 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    check("rst_issue_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check_reset_vals("rst_issue");
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check_reset_vals("rst_release");
    drive_dout(1'b1, 1'b1, {32'd6, 32'd4});
    tick();
    drive_dout(1'b1, 1'b0, '0);
    check("stale_busy", 64'(busy), 64'(0));
    check("stale_resp_valid", 64'(resp_valid), 64'(0));
    run_op(1'b1, 1'b1, 32'd40, 32'd6, 1, 2, 1, 0, ModeNormal, 1);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      sgn  = 1'($urandom);
      rem  = 1'($urandom);
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (b == 0) b = 32'd1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      mode = $urandom_range(0, 4);
      dvd  = $urandom_range(0, 3);
      dvs  = $urandom_range(0, 3);
      lat  = $urandom_range(0, 6);
      fl   = 0;
      if (mode == ModeFlushIss0) begin
        dvd = $urandom_range(1, 3);
        dvs = $urandom_range(1, 3);
      end else if (mode == ModeFlushIss1) begin
        dvd = 0;
        dvs = $urandom_range(2, 3);
      end else if (mode == ModeFlushWait) begin
        lat = $urandom_range(1, 8);
        fl  = $urandom_range(0, lat - 1);
      end
      run_op(sgn, rem, a, b, dvd, dvs, lat, fl, mode, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
